// File: rtl/uart_frame_reader_pkg.sv
// Shared types for the UART frame reader: FSM state encoding and frame word count.
// The word count includes the trailing checksum word when UART_FRAME_CHECKSUM_EN is defined.
package uart_frame_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, POP, LATCH, DONE, ERROR} uart_frame_state_t;

    function automatic int total_words(input int num_bytes);
`ifdef UART_FRAME_CHECKSUM_EN
        return num_bytes + 1;
`else
        return num_bytes;
`endif
    endfunction

endpackage

// File: rtl/uart_frame_reader_if.sv
// Bus between the RX FIFO / security controller (master) and the frame reader (slave).
// chk_err exists only when UART_FRAME_CHECKSUM_EN is defined.
interface uart_frame_reader_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_BYTES = 4
);
    localparam int CNT_W = $clog2(NUM_BYTES + 2);

    logic                        start;
    logic                        rxempty;
    logic [DATA_W-1:0]           rxdata;
    logic                        uldrxdata;
    logic [NUM_BYTES*DATA_W-1:0] frame;
    logic [CNT_W-1:0]            count;
    logic                        busy;
    logic                        done;
    logic                        timeout_err;
`ifdef UART_FRAME_CHECKSUM_EN
    logic                        chk_err;

    modport master (output start, rxempty, rxdata,
                    input  uldrxdata, frame, count, busy, done, timeout_err, chk_err);
    modport slave  (input  start, rxempty, rxdata,
                    output uldrxdata, frame, count, busy, done, timeout_err, chk_err);
`else
    modport master (output start, rxempty, rxdata,
                    input  uldrxdata, frame, count, busy, done, timeout_err);
    modport slave  (input  start, rxempty, rxdata,
                    output uldrxdata, frame, count, busy, done, timeout_err);
`endif

endinterface

// File: rtl/uart_frame_reader_timer.sv
// Idle-FIFO watchdog: clear/enable counter whose tc flag marks the last allowed wait cycle.
// TIMEOUT_CYC = 0 disables the watchdog (tc tied low).
module uart_frame_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign tc = 1'b0;
        end else begin : g_on
            logic [TW-1:0] cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt <= '0;
                else if (clr)
                    cnt <= '0;
                else if (en)
                    cnt <= cnt + TW'(1);
            end

            // The FSM leaves WAIT on tc, so the counter never advances past TIMEOUT_CYC-1.
            assign tc = (cnt == TW'(TIMEOUT_CYC - 1));
        end
    endgenerate

endmodule

// File: rtl/uart_frame_reader.sv
// Pops NUM_BYTES words from the UART RX FIFO into one MSW-first frame, with idle watchdog.
// Optional trailing checksum word checked when UART_FRAME_CHECKSUM_EN is defined.
module uart_frame_reader
    import uart_frame_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_BYTES   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               reset,
    uart_frame_reader_if.slave bus
);
    localparam int TOTAL   = total_words(NUM_BYTES);
    localparam int CNT_W   = $clog2(NUM_BYTES + 2);
    localparam int FRAME_W = NUM_BYTES * DATA_W;

    uart_frame_state_t  state;
    logic [FRAME_W-1:0] frame_r;
    logic [CNT_W-1:0]   count_r;
    logic               uld_r;
    logic               busy_r;
    logic               done_r;
    logic               terr_r;
    logic               start_ok;
    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_tc;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [DATA_W-1:0]  sum_r;
    logic               chk_r;
`endif

    assign start_ok = bus.start && (state == IDLE || state == DONE || state == ERROR);
    assign tmr_clr  = start_ok || (state == POP);
    assign tmr_en   = (state == WAIT) && bus.rxempty && !tmr_tc;

    uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            frame_r <= '0;
            count_r <= '0;
            uld_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            terr_r  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_r   <= '0;
            chk_r   <= 1'b0;
`endif
        end else begin
            uld_r <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state   <= WAIT;
                        count_r <= '0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        terr_r  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
                        sum_r   <= '0;
                        chk_r   <= 1'b0;
`endif
                    end
                end
                WAIT: begin
                    if (!bus.rxempty) begin
                        state <= POP;
                        uld_r <= 1'b1;
                    end else if (tmr_tc) begin
                        state  <= ERROR;
                        busy_r <= 1'b0;
                        terr_r <= 1'b1;
                    end
                end
                POP: state <= LATCH;
                LATCH: begin
                    // rxdata is valid here, one cycle after the pop strobe.
                    for (int k = 0; k < NUM_BYTES; k++)
                        if (count_r == CNT_W'(k))
                            frame_r[(NUM_BYTES-1-k)*DATA_W +: DATA_W] <= bus.rxdata;
`ifdef UART_FRAME_CHECKSUM_EN
                    if (count_r < CNT_W'(NUM_BYTES))
                        sum_r <= sum_r + bus.rxdata;
                    else
                        chk_r <= (bus.rxdata != sum_r);
`endif
                    count_r <= count_r + CNT_W'(1);
                    if (count_r == CNT_W'(TOTAL - 1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.uldrxdata   = uld_r;
    assign bus.frame       = frame_r;
    assign bus.count       = count_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.timeout_err = terr_r;
`ifdef UART_FRAME_CHECKSUM_EN
    assign bus.chk_err     = chk_r;
`endif

endmodule

// File: tb/tb_uart_frame_reader.sv
// Bench for uart_frame_reader: FIFO model with random data/stalls, frame/latency/timeout checks.
// Checksum cases are included when UART_FRAME_CHECKSUM_EN is defined.
module tb_uart_frame_reader;
    import uart_frame_pkg::*;

    localparam int NB    = 4;
    localparam int TOTAL = total_words(NB);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_frame_reader_if #(.DATA_W(8), .NUM_BYTES(NB)) ifc ();
    uart_frame_reader_if #(.DATA_W(8), .NUM_BYTES(NB)) ifc2 ();

    uart_frame_reader #(.DATA_W(8), .NUM_BYTES(NB), .TIMEOUT_CYC(1000)) dut (
        .clk(clk), .reset(reset), .bus(ifc.slave));
    uart_frame_reader #(.DATA_W(8), .NUM_BYTES(NB), .TIMEOUT_CYC(20)) dut_to (
        .clk(clk), .reset(reset), .bus(ifc2.slave));

    int         nvec = 0;
    int         nerr = 0;
    int         npops = 0;
    int         stall_pct = 0;
    bit         pend = 0;
    bit         stall = 0;
    bit         prev_empty = 1;
    bit         prev_uld = 0;
    bit         to_pop = 0;
    logic [7:0] fifo[$];
`ifdef UART_FRAME_CHECKSUM_EN
    bit         corrupt = 0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*8-1:0] model_frame(input logic [7:0] w[NB]);
        logic [NB*8-1:0] acc = '0;
        foreach (w[i]) acc = {acc[NB*8-9:0], w[i]};
        return acc;
    endfunction

    task automatic set_empty();
        ifc.rxempty = (fifo.size() == 0) || stall;
    endtask

    // One clock: pop the FIFO model after a strobe, drive rxempty, then sample at negedge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (pend) begin
            if (fifo.size() > 0) ifc.rxdata = fifo.pop_front();
            npops++;
            pend = 0;
        end
        prev_empty = ifc.rxempty;
        stall = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
        set_empty();
        @(negedge clk);
        if (ifc.uldrxdata) begin
            chk("pop_legal", 64'({prev_uld, prev_empty, fifo.size() == 0}), 64'(3'b000));
            pend = 1;
        end
        prev_uld = ifc.uldrxdata;
        if (ifc2.uldrxdata) to_pop = 1;
    endtask

    task automatic start_pulse();
        ifc.start = 1'b1;
        cyc();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int edges);
        edges = 0;
        while (!ifc.done && edges < bound) begin
            cyc();
            edges++;
        end
    endtask

    task automatic push_words(input logic [7:0] w[NB], input int lo, input int hi);
        for (int i = lo; i <= hi; i++) fifo.push_back(w[i]);
    endtask

`ifdef UART_FRAME_CHECKSUM_EN
    task automatic push_chk(input logic [7:0] w[NB]);
        int s = 0;
        foreach (w[i]) s += int'(w[i]);
        fifo.push_back(8'(s) ^ {7'b0, corrupt});
    endtask
`endif

    task automatic check_end(input string tag, input logic [7:0] w[NB], input int p0);
        chk({tag, "_flags"}, 64'({ifc.done, ifc.busy, ifc.timeout_err}), 64'(3'b100));
        chk({tag, "_frame"}, 64'(ifc.frame), 64'(model_frame(w)));
        chk({tag, "_count"}, 64'(ifc.count), 64'(TOTAL));
        chk({tag, "_pops"}, 64'(npops - p0), 64'(TOTAL));
`ifdef UART_FRAME_CHECKSUM_EN
        chk({tag, "_chk_err"}, 64'(ifc.chk_err), 64'(corrupt));
`endif
    endtask

    task automatic run_frame(input logic [7:0] w[NB], input int pct, input string tag);
        int e;
        int p0 = npops;
        logic [NB*8-1:0] oldf = ifc.frame;
        push_words(w, 0, NB - 1);
`ifdef UART_FRAME_CHECKSUM_EN
        push_chk(w);
`endif
        set_empty();
        stall_pct = pct;
        start_pulse();
        chk({tag, "_clr"}, 64'({ifc.done, ifc.timeout_err, ifc.busy, ifc.count}), 64'({3'b001, 3'b000}));
        chk({tag, "_keep"}, 64'(ifc.frame), 64'(oldf));
        wait_done(3 * TOTAL + 400, e);
        stall_pct = 0;
        check_end(tag, w, p0);
        if (pct == 0) chk({tag, "_latency"}, 64'(e), 64'(3 * TOTAL));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] w[NB];
        int e;
        int p0;
        ifc.start = 0; ifc.rxempty = 1; ifc.rxdata = '0;
        ifc2.start = 0; ifc2.rxempty = 1; ifc2.rxdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst_state", 64'({ifc.frame, ifc.count, ifc.uldrxdata, ifc.busy, ifc.done, ifc.timeout_err}), 64'(0));
`ifdef UART_FRAME_CHECKSUM_EN
        chk("rst_chk_err", 64'(ifc.chk_err), 64'(0));
`endif
        reset = 0;
        cyc();

        // Full FIFO, fixed data, exact latency
        w = '{8'h74, 8'h12, 8'hA5, 8'h3C};
        run_frame(w, 0, "t2");
        chk("t2_const", 64'(ifc.frame), 64'(32'h7412A53C));

        // Random data, alternating back-to-back and random short stalls
        for (int it = 0; it < 8; it++) begin
            foreach (w[i]) w[i] = 8'($urandom);
`ifdef UART_FRAME_CHECKSUM_EN
            corrupt = 1'($urandom_range(0, 1));
`endif
            run_frame(w, (it % 2) ? 25 : 0, "rnd");
        end

        // 50-cycle empty FIFO between words 2 and 3
        foreach (w[i]) w[i] = 8'($urandom);
`ifdef UART_FRAME_CHECKSUM_EN
        corrupt = 0;
`endif
        p0 = npops;
        push_words(w, 0, 1);
        set_empty();
        start_pulse();
        for (int i = 0; i < 40 && npops - p0 < 2; i++) cyc();
        repeat (50) cyc();
        chk("stall_hold", 64'({ifc.busy, ifc.timeout_err, ifc.done, ifc.count}), 64'({3'b100, 3'd2}));
        chk("stall_pops", 64'(npops - p0), 64'(2));
        push_words(w, 2, NB - 1);
`ifdef UART_FRAME_CHECKSUM_EN
        push_chk(w);
`endif
        set_empty();
        wait_done(100, e);
        check_end("stall", w, p0);

        // start while busy is ignored
        foreach (w[i]) w[i] = 8'($urandom);
        p0 = npops;
        push_words(w, 0, NB - 1);
`ifdef UART_FRAME_CHECKSUM_EN
        push_chk(w);
`endif
        set_empty();
        start_pulse();
        repeat (6) cyc();
        ifc.start = 1'b1;
        cyc();
        ifc.start = 1'b0;
        chk("busy_start", 64'({ifc.busy, ifc.done, ifc.count}), 64'({2'b10, 3'd2}));
        wait_done(100, e);
        chk("busy_latency", 64'(e), 64'(3 * TOTAL - 7));
        check_end("busy", w, p0);

`ifdef UART_FRAME_CHECKSUM_EN
        // Checksum good and bad
        w = '{8'h01, 8'h02, 8'h03, 8'h04};
        corrupt = 0;
        run_frame(w, 0, "cs_ok");
        chk("cs_ok_word", 64'(fifo.size()), 64'(0));
        corrupt = 1;
        run_frame(w, 0, "cs_bad");
`endif

        // Watchdog on the TIMEOUT_CYC=20 instance
        for (int r = 0; r < 2; r++) begin
            ifc2.start = 1'b1;
            cyc();
            ifc2.start = 1'b0;
            chk("to_busy", 64'({ifc2.timeout_err, ifc2.busy, ifc2.done}), 64'(3'b010));
            repeat (19) cyc();
            chk("to_wait19", 64'({ifc2.timeout_err, ifc2.busy}), 64'(2'b01));
            cyc();
            chk("to_err", 64'({ifc2.timeout_err, ifc2.busy, ifc2.done}), 64'(3'b100));
        end
        chk("to_nopop", 64'(to_pop), 64'(0));

        // Asynchronous reset in LATCH
        foreach (w[i]) w[i] = 8'($urandom);
        push_words(w, 0, NB - 1);
        set_empty();
        start_pulse();
        cyc();
        cyc();
        p0 = npops;
        reset = 1'b1;
        #1;
        chk("rst_latch", 64'({ifc.frame, ifc.count, ifc.uldrxdata, ifc.busy, ifc.done, ifc.timeout_err}), 64'(0));
        repeat (2) cyc();
        reset = 1'b0;
        repeat (10) cyc();
        chk("rst_nopop", 64'({npops - p0, ifc.busy, ifc.count}), 64'(0));
        fifo.delete();
        set_empty();
        foreach (w[i]) w[i] = 8'($urandom);
`ifdef UART_FRAME_CHECKSUM_EN
        corrupt = 0;
`endif
        run_frame(w, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
